// File: rtl/track_drive_ctrl.sv
// track_drive_ctrl
// Line-following sequencer that drives the 3-bit command input of the motor
// PWM generator. It debounces the three IR line sensors, turns the filtered
// pattern into a steering code, and runs a lost-line recovery sequence. The
// recovery sequence holds the heading, reverses, then retries. The block
// halts on a stop marker or after repeated failed recoveries.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous, active-low reset
//   sensor_in  {L,M,R} raw IR sensors, 1 = line seen
//   start      single-cycle pulse, IDLE/HALT -> RUN
//   stop_req   level, forces IDLE (wins over start)
//   ctr        PWM command (000 fwd, 010 boost, 101/100 left, 110/111 right,
//              011 reverse, 001 stop)
//   state_out  IDLE=0, RUN=1, LOST=2, REVERSE=3, HALT=4
//   fault      1 = halted after MAX_RETRY failed recoveries
//
// Optional feature: define BOOST_EN to switch straight running (sf=010) to
// the boost code after HOLD_CYC cycles. Without it, 010 is never issued.

module track_drive_ctrl #(
  parameter int CNT_W     = 24,
  parameter int FILT_CYC  = 50000,
  parameter int HOLD_CYC  = 5000000,
  parameter int LOST_CYC  = 2500000,
  parameter int BACK_CYC  = 10000000,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sensor_in,
  input  logic       start,
  input  logic       stop_req,
  output logic [2:0] ctr,
  output logic [2:0] state_out,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    LOST    = 3'd2,
    REVERSE = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [2:0] C_FWD  = 3'b000;
  localparam logic [2:0] C_LG   = 3'b101;
  localparam logic [2:0] C_LS   = 3'b100;
  localparam logic [2:0] C_RG   = 3'b110;
  localparam logic [2:0] C_RS   = 3'b111;
  localparam logic [2:0] C_REV  = 3'b011;
  localparam logic [2:0] C_STOP = 3'b001;
`ifdef BOOST_EN
  localparam logic [2:0] C_BOOST = 3'b010;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] FILT_LIM = CNT_W'(FILT_CYC);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] LOST_LIM = CNT_W'(LOST_CYC);
  localparam logic [CNT_W-1:0] BACK_LIM = CNT_W'(BACK_CYC);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  state_t             state;
  logic [2:0]         sense_prev;
  logic [2:0]         sf;
  logic [CNT_W-1:0]   filt_cnt;
  logic [CNT_W-1:0]   filt_next;
  logic [CNT_W-1:0]   tmr;
  logic [CNT_W-1:0]   tmr_inc;
  logic [RETRY_W-1:0] retry;
  logic [2:0]         steer;
  logic [2:0]         steer_code;
`ifdef BOOST_EN
  logic [CNT_W-1:0]   bst;
  logic [CNT_W-1:0]   bst_inc;
`endif

  assign state_out = state;

  // filt_next is the length of the current run of identical samples,
  // counting this one. A new value restarts the run at 1.
  always_comb begin
    if (sensor_in != sense_prev) begin
      filt_next = CNT_ONE;
    end else if (filt_cnt != CNT_MAX) begin
      filt_next = filt_cnt + CNT_ONE;
    end else begin
      filt_next = filt_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sense_prev <= 3'b000;
      filt_cnt   <= '0;
      sf         <= 3'b000;
    end else begin
      sense_prev <= sensor_in;
      filt_cnt   <= filt_next;
      if (filt_next >= FILT_LIM) begin
        sf <= sensor_in;
      end
    end
  end

  // One state timer serves RUN, LOST and REVERSE. It is cleared on every
  // state entry and saturates instead of wrapping.
  assign tmr_inc = (tmr != CNT_MAX) ? tmr + CNT_ONE : tmr;
`ifdef BOOST_EN
  assign bst_inc = (bst != CNT_MAX) ? bst + CNT_ONE : bst;
`endif

  // Steering decode. Invalid patterns (101) hold the last steering code.
  always_comb begin
    steer_code = steer;
    case (sf)
      3'b010:  steer_code = C_FWD;
      3'b110:  steer_code = C_LG;
      3'b100:  steer_code = C_LS;
      3'b011:  steer_code = C_RG;
      3'b001:  steer_code = C_RS;
      default: steer_code = steer;
    endcase
`ifdef BOOST_EN
    if (sf == 3'b010 && bst_inc >= HOLD_LIM) begin
      steer_code = C_BOOST;
    end
`endif
  end

  // Main sequencer. steer remembers the last code issued in RUN, so LOST can
  // keep that heading even after a REVERSE spell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctr   <= C_STOP;
      fault <= 1'b0;
      retry <= '0;
      tmr   <= '0;
      steer <= C_STOP;
`ifdef BOOST_EN
      bst   <= '0;
`endif
    end else begin
`ifdef BOOST_EN
      bst <= '0;
`endif
      if (stop_req) begin
        state <= IDLE;
        ctr   <= C_STOP;
        fault <= 1'b0;
        tmr   <= '0;
      end else if (start && (state == IDLE || state == HALT)) begin
        state <= RUN;
        ctr   <= C_STOP;
        fault <= 1'b0;
        retry <= '0;
        tmr   <= '0;
        steer <= C_STOP;
      end else begin
        case (state)
          IDLE, HALT: begin
            ctr <= C_STOP;
          end
          RUN: begin
            // A long enough clean run earns back every recovery attempt.
            tmr <= tmr_inc;
            if (tmr_inc >= HOLD_LIM) begin
              retry <= '0;
            end
            if (sf == 3'b111) begin
              state <= HALT;
              ctr   <= C_STOP;
              fault <= 1'b0;
              tmr   <= '0;
            end else if (sf == 3'b000) begin
              state <= LOST;
              ctr   <= steer;
              tmr   <= '0;
            end else begin
              ctr   <= steer_code;
              steer <= steer_code;
`ifdef BOOST_EN
              bst   <= (sf == 3'b010) ? bst_inc : '0;
`endif
            end
          end
          LOST: begin
            if (sf != 3'b000) begin
              state <= RUN;
              ctr   <= steer;
              tmr   <= '0;
            end else if (tmr_inc >= LOST_LIM) begin
              tmr <= '0;
              if (retry == RETRY_LIM) begin
                state <= HALT;
                ctr   <= C_STOP;
                fault <= 1'b1;
              end else begin
                state <= REVERSE;
                ctr   <= C_REV;
                retry <= retry + RETRY_ONE;
              end
            end else begin
              tmr <= tmr_inc;
              ctr <= steer;
            end
          end
          REVERSE: begin
            if (sf != 3'b000) begin
              state <= RUN;
              ctr   <= C_REV;
              tmr   <= '0;
            end else if (tmr_inc >= BACK_LIM) begin
              state <= LOST;
              ctr   <= steer;
              tmr   <= '0;
            end else begin
              tmr <= tmr_inc;
              ctr <= C_REV;
            end
          end
          default: begin
            state <= IDLE;
            ctr   <= C_STOP;
            tmr   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_track_drive_ctrl.sv
// tb_track_drive_ctrl
// Self-checking bench for track_drive_ctrl with short timer parameters.
// A behavioural model keeps the filtered sensor value, the state, the time
// spent in the state and the retry count, and works out the expected command
// every clock. Outputs are compared on each falling edge. Directed scenarios
// walk through steering, glitch rejection, lost-line recovery, retry refresh,
// the stop marker, start/stop priority and async reset. A randomized phase
// follows them. Define BOOST_EN for both the bench and the design to cover boost.

module tb_track_drive_ctrl;

  localparam int FILT = 4;
  localparam int HOLD = 16;
  localparam int LOSTC = 20;
  localparam int BACK = 30;
  localparam int MAXR = 2;

  localparam int S_IDLE = 0;
  localparam int S_RUN = 1;
  localparam int S_LOST = 2;
  localparam int S_REV = 3;
  localparam int S_HALT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] sensor_in = 3'b000;
  logic       start = 1'b0;
  logic       stop_req = 1'b0;
  logic [2:0] ctr;
  logic [2:0] state_out;
  logic       fault;

  int testCount = 0;
  int failCount = 0;

  // Model state
  logic [2:0] mSf = 3'b000;
  logic [2:0] mLastSamp = 3'b000;
  int mRunLen = 0;
  int mState = S_IDLE;
  int mCtr = 1;
  int mFault = 0;
  int mRetry = 0;
  int mLast = 1;
  int mDwell = 0;
  int mStraight = 0;

  // Steering table indexed by filtered pattern; -1 marks the patterns that
  // are handled specially (lost, invalid, stop marker).
  int steerTab [8] = '{-1, 7, 0, 6, 4, -1, 5, -1};

  track_drive_ctrl #(
    .CNT_W(24),
    .FILT_CYC(FILT),
    .HOLD_CYC(HOLD),
    .LOST_CYC(LOSTC),
    .BACK_CYC(BACK),
    .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sensor_in(sensor_in),
    .start(start),
    .stop_req(stop_req),
    .ctr(ctr),
    .state_out(state_out),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [2:0] observed,
                             input logic [2:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mSf = 3'b000;
    mLastSamp = 3'b000;
    mRunLen = 0;
    mState = S_IDLE;
    mCtr = 1;
    mFault = 0;
    mRetry = 0;
    mLast = 1;
    mDwell = 0;
    mStraight = 0;
  endtask

  task automatic enterState(input int s);
    mState = s;
    mDwell = 0;
    mStraight = 0;
  endtask

  // One clock of the reference behaviour. The sequencer acts on the filtered
  // value as it stood before this edge.
  task automatic modelStep();
    logic [2:0] sfOld;
    int code;
    sfOld = mSf;
    if (sensor_in == mLastSamp) mRunLen++;
    else mRunLen = 1;
    mLastSamp = sensor_in;
    if (mRunLen >= FILT) mSf = sensor_in;

    if (stop_req) begin
      enterState(S_IDLE);
      mCtr = 1;
      mFault = 0;
    end else if (start && (mState == S_IDLE || mState == S_HALT)) begin
      enterState(S_RUN);
      mRetry = 0;
      mFault = 0;
      mLast = 1;
      mCtr = 1;
    end else begin
      case (mState)
        S_RUN: begin
          mDwell++;
          if (mDwell >= HOLD) mRetry = 0;
          if (sfOld == 3'b111) begin
            enterState(S_HALT);
            mCtr = 1;
            mFault = 0;
          end else if (sfOld == 3'b000) begin
            enterState(S_LOST);
            mCtr = mLast;
          end else begin
            if (sfOld == 3'b010) mStraight++;
            else mStraight = 0;
            code = (sfOld == 3'b101) ? mLast : steerTab[sfOld];
`ifdef BOOST_EN
            if (sfOld == 3'b010 && mStraight >= HOLD) code = 2;
`endif
            mCtr = code;
            mLast = code;
          end
        end
        S_LOST: begin
          if (sfOld != 3'b000) begin
            enterState(S_RUN);
            mCtr = mLast;
          end else begin
            mDwell++;
            if (mDwell >= LOSTC) begin
              if (mRetry == MAXR) begin
                enterState(S_HALT);
                mFault = 1;
                mCtr = 1;
              end else begin
                enterState(S_REV);
                mRetry++;
                mCtr = 3;
              end
            end else begin
              mCtr = mLast;
            end
          end
        end
        S_REV: begin
          if (sfOld != 3'b000) begin
            enterState(S_RUN);
            mCtr = 3;
          end else begin
            mDwell++;
            if (mDwell >= BACK) begin
              enterState(S_LOST);
              mCtr = mLast;
            end else begin
              mCtr = 3;
            end
          end
        end
        default: mCtr = 1;
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cyc_ctr", ctr, 3'(mCtr));
      checkOutput("cyc_state", state_out, 3'(mState));
      checkOutput("cyc_fault", {2'b00, fault}, 3'(mFault));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitState(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (state_out !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, state_out, target);
  endtask

  task automatic enterRun();
    sensor_in = 3'b010;
    tick(6);
    pulseStart();
    tick(2);
  endtask

  // Random segments of held sensor patterns with occasional start and stop.
  task automatic applyStimulus(input int segments);
    logic [2:0] pats [6] = '{3'b010, 3'b110, 3'b100, 3'b011, 3'b001, 3'b101};
    for (int i = 0; i < segments; i++) begin
      int pick;
      int hold;
      pick = $urandom_range(0, 11);
      if (pick < 3) sensor_in = 3'b000;
      else if (pick == 11) sensor_in = 3'b111;
      else sensor_in = pats[$urandom_range(0, 5)];
      hold = (sensor_in == 3'b000) ? $urandom_range(1, 70) : $urandom_range(1, 12);
      if ((mState == S_IDLE || mState == S_HALT) && $urandom_range(0, 1) == 1) start = 1'b1;
      else if ($urandom_range(0, 15) == 0) start = 1'b1;
      if ($urandom_range(0, 24) == 0) stop_req = 1'b1;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        start = 1'b0;
        stop_req = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset and first start with a straight line under the sensors.
    sensor_in = 3'b010;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_ctr", ctr, 3'd1);
    checkOutput("rst_state", state_out, 3'd0);
    checkOutput("rst_fault", {2'b00, fault}, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(6);
    checkOutput("idle_before_start", state_out, 3'd0);
    pulseStart();
    checkOutput("start_state", state_out, 3'd1);
    tick(1);
    checkOutput("fwd_ctr", ctr, 3'd0);
    tick(15);
`ifdef BOOST_EN
    checkOutput("boost_ctr", ctr, 3'd2);
`else
    checkOutput("straight_ctr", ctr, 3'd0);
`endif

    // Steering and glitch rejection.
    sensor_in = 3'b110;
    tick(5);
    checkOutput("left_gentle", ctr, 3'd5);
    sensor_in = 3'b001;
    tick(3);
    sensor_in = 3'b110;
    tick(8);
    checkOutput("glitch_ignored", ctr, 3'd5);
    sensor_in = 3'b001;
    tick(5);
    checkOutput("right_sharp", ctr, 3'd7);
    sensor_in = 3'b101;
    tick(6);
    checkOutput("invalid_hold", ctr, 3'd7);

    // Lost line: hold heading, two reverses, then halt with fault.
    sensor_in = 3'b000;
    waitState(3'd2, 12, "lost_enter");
    checkOutput("lost_hold_ctr", ctr, 3'd7);
    waitState(3'd3, 25, "rev1");
    checkOutput("rev1_ctr", ctr, 3'd3);
    waitState(3'd2, 35, "rev1_back");
    checkOutput("relost_ctr", ctr, 3'd7);
    waitState(3'd3, 25, "rev2");
    waitState(3'd2, 35, "rev2_back");
    waitState(3'd4, 25, "halt_retry");
    checkOutput("halt_ctr", ctr, 3'd1);
    checkOutput("halt_fault", {2'b00, fault}, 3'd1);

    // Recovery from REVERSE, then a long run restores both retries.
    enterRun();
    checkOutput("fault_cleared", {2'b00, fault}, 3'd0);
    sensor_in = 3'b000;
    waitState(3'd2, 12, "lost_a");
    waitState(3'd3, 25, "rev_a");
    sensor_in = 3'b010;
    waitState(3'd1, 10, "rev_to_run");
    tick(1);
    checkOutput("rev_run_ctr", ctr, 3'd0);
    tick(20);
    sensor_in = 3'b000;
    waitState(3'd2, 12, "lost_b");
    waitState(3'd3, 25, "rev_b");
    waitState(3'd2, 35, "lost_c");
    waitState(3'd3, 25, "rev_c");
    waitState(3'd2, 35, "lost_d");
    waitState(3'd4, 25, "halt_again");
    checkOutput("halt_again_fault", {2'b00, fault}, 3'd1);

    // Stop marker, then start and stop together.
    enterRun();
    sensor_in = 3'b111;
    waitState(3'd4, 10, "marker_halt");
    checkOutput("marker_fault", {2'b00, fault}, 3'd0);
    checkOutput("marker_ctr", ctr, 3'd1);
    start = 1'b1;
    stop_req = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop_req = 1'b0;
    checkOutput("start_stop_idle", state_out, 3'd0);
    checkOutput("start_stop_ctr", ctr, 3'd1);

    // Async reset in the middle of a reverse.
    enterRun();
    sensor_in = 3'b000;
    waitState(3'd3, 40, "rev_for_reset");
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_ctr", ctr, 3'd1);
    checkOutput("async_state", state_out, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sensor_in = 3'b010;
    tick(10);
    checkOutput("needs_start", state_out, 3'd0);
    pulseStart();
    checkOutput("restart_state", state_out, 3'd1);

    applyStimulus(180);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/track_drive_ctrl.md
Name: track_drive_ctrl

Overview:
- Line-following sequencer that drives the 3-bit `ctr` command input of the motor PWM generator.
- Filters the 3 IR line sensors and maps them to steering codes.
- Runs a lost-line recovery sequence (hold heading, reverse, retry) and halts on a stop marker or repeated failure.
- Sits between the sensor pins and the PWM block. `ctr` connects directly to the PWM `ctr` input.

Parameters:
- CNT_W, 24, width of all internal timers.
- FILT_CYC, 50000, consecutive stable cycles before a raw sensor change is accepted (1 ms at 50 MHz).
- HOLD_CYC, 5000000, straight-run time before boost; also RUN time that clears the retry count.
- LOST_CYC, 2500000, time in LOST before reversing.
- BACK_CYC, 10000000, maximum reverse duration.
- MAX_RETRY, 3, reverse attempts allowed before HALT with fault.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- sensor_in  in  3  {L,M,R} raw IR; 1 = line seen
- start  in  1  single-cycle pulse; IDLE/HALT -> RUN
- stop_req  in  1  level; forces IDLE
- ctr  out  3  PWM command: 000 fwd, 010 fwd boost, 101 left gentle, 100 left sharp, 110 right gentle, 111 right sharp, 011 reverse, 001 stop
- state_out  out  3  IDLE=0, RUN=1, LOST=2, REVERSE=3, HALT=4
- fault  out  1  1 = halted after MAX_RETRY failed recoveries

Behaviour:
- Reset (async, immediate):
  - state IDLE, ctr=001, fault=0.
  - Filtered sensor sf=000, retry=0, all timers 0.
  - Reset asserted mid-operation drops ctr to 001 with no clock edge.
- Filter:
  - Filter timer restarts whenever sensor_in differs from the previous sample.
  - sf takes sensor_in when sensor_in has been stable for FILT_CYC cycles.
  - Glitches shorter than FILT_CYC never reach sf.
- ctr and state_out are registered, 1 cycle after the state/sf change.
- Priority each cycle: stop_req > start > state logic. If start and stop_req are both asserted in the same cycle, the result is IDLE.
- IDLE:
  - ctr=001.
  - start -> RUN; retry=0, fault=0.
- RUN, mapping from sf:
  - 010 -> 000 (boost rule under BOOST_EN).
  - 110 -> 101.
  - 100 -> 100.
  - 011 -> 110.
  - 001 -> 111.
  - 111 -> HALT (stop marker), fault=0.
  - 000 -> LOST; lost timer=0.
  - 101 -> invalid; ctr holds its previous value.
  - Retry clear: a run timer counts cycles continuously in RUN; retry clears when it reaches HOLD_CYC.
- LOST:
  - ctr holds the last RUN steering code.
  - sf != 000 -> RUN.
  - Lost timer reaching LOST_CYC:
    - retry == MAX_RETRY -> HALT, fault=1.
    - otherwise -> REVERSE, retry+1.
- REVERSE:
  - ctr=011.
  - sf != 000 -> RUN.
  - After BACK_CYC cycles -> LOST, lost timer restarted.
- HALT:
  - ctr=001; fault holds.
  - start -> RUN; retry=0, fault=0.
- Timers saturate and never wrap. All timers reset on every state entry.

Optional Feature:
- BOOST_EN defined: in RUN, sf=010 held continuously for HOLD_CYC cycles switches ctr 000 -> 010. Any sf change returns ctr to normal mapping on the next update.
- BOOST_EN undefined: straight is always 000, and code 010 is never issued.

Test Plan:
- Bench parameters for all scenarios: FILT_CYC=4, HOLD_CYC=16, LOST_CYC=20, BACK_CYC=30, MAX_RETRY=2.
- Reset, then start pulse with sensor_in=010:
  - state 1; ctr=000 by filter + 1 cycle.
  - With BOOST_EN: ctr=010 after 16 more cycles.
- In RUN:
  - sensor_in=110 for 4 cycles -> ctr=101.
  - 3-cycle 001 glitch -> ctr unchanged.
  - sensor_in=001 held -> ctr=111.
- sensor_in=000 held:
  - LOST (ctr keeps last code).
  - REVERSE (ctr=011) after 20 cycles.
  - 30 cycles later LOST again; after 2 reverses -> HALT, ctr=001, fault=1.
- In REVERSE, sensor_in=010 for 4 cycles -> RUN, ctr=000. After 16 RUN cycles retry=0, so the full 2 retries are available again.
- sensor_in=111 -> HALT, fault=0. Then start with stop_req=1 in the same cycle -> IDLE, ctr=001.
- rst_n low mid-REVERSE -> ctr=001 and state_out=0 without a clock edge; after release, start is required to move.
